// File: rtl/test_pattern_pkg.sv
// Shared encodings and colour constants for the HDMI test-pattern source.
package test_pattern_pkg;

  // Pattern select; values 5-7 are legal inputs and render black.
  typedef enum logic [2:0] {
    MODE_GRID   = 3'd0,
    MODE_BARS   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_SOLID  = 3'd3,
    MODE_MOVBAR = 3'd4
  } mode_e;

  // Colours as {R,G,B} full-on/full-off masks, widened to COLOR_W at the point of use.
  typedef logic [2:0] rgb_mask_t;

  localparam rgb_mask_t BLACK = 3'b000;
  localparam rgb_mask_t WHITE = 3'b111;
  localparam rgb_mask_t RED   = 3'b100;
  localparam rgb_mask_t GREEN = 3'b010;

  // Classic colour-bar order, left to right.
  localparam rgb_mask_t BAR_COLORS [8] = '{
    WHITE,   // white
    3'b110,  // yellow
    3'b011,  // cyan
    GREEN,   // green
    3'b101,  // magenta
    RED,     // red
    3'b001,  // blue
    BLACK    // black
  };

endpackage

// File: rtl/pattern_phase_counter.sv
// Modulo-N phase counter. phase_o/toggle_o are the values for the current cycle: clear wins,
// otherwise an enabled cycle shows the advanced value, which is also what gets stored.
module pattern_phase_counter #(
  parameter int unsigned Modulus = 25,
  parameter int unsigned Width   = 5
) (
  input  logic             hdmi_clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] phase_o,
  output logic             toggle_o
);

  logic [Width-1:0] phase_q;
  logic             toggle_q;
  logic             wrap;

  assign wrap = (phase_q == Width'(Modulus - 1));

  // Current-cycle phase and wrap-toggle.
  always_comb begin
    phase_o  = phase_q;
    toggle_o = toggle_q;
    if (clear_i) begin
      phase_o  = '0;
      toggle_o = 1'b0;
    end else if (en_i) begin
      phase_o  = wrap ? '0 : phase_q + Width'(1);
      toggle_o = wrap ? ~toggle_q : toggle_q;
    end
  end

  // Hold the current-cycle values for the next cycle.
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      phase_q  <= '0;
      toggle_q <= 1'b0;
    end else begin
      phase_q  <= phase_o;
      toggle_q <= toggle_o;
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode HDMI test-pattern source with a registered RGB output and a frame heartbeat.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 1920,
  parameter int unsigned V_ACTIVE        = 1080,
  parameter int unsigned COORD_W         = 12,
  parameter int unsigned COLOR_W         = 8,
  parameter int unsigned GRID_SPACING    = 25,
  parameter int unsigned BAR_STEP        = 4,
  parameter int unsigned FRAMES_PER_BEAT = 60,
  parameter int unsigned HB_W            = 8
) (
  input  logic                 hdmi_clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic                 de,
  input  logic                 next_frame,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   out_r,
  output logic [COLOR_W-1:0]   out_g,
  output logic [COLOR_W-1:0]   out_b,
  output logic                 out_de,
  output logic [HB_W-1:0]      heartbeat
);

  localparam int unsigned PhaseW    = $clog2(GRID_SPACING);
  localparam int unsigned BarW      = H_ACTIVE / 8;
  localparam int unsigned FrameCtrW = (FRAMES_PER_BEAT > 1) ? $clog2(FRAMES_PER_BEAT) : 1;
  localparam int unsigned CoordW1   = COORD_W + 1;

  logic                 next_frame_q;
  logic                 frame_edge;
  mode_e                mode_q;
  logic [FrameCtrW-1:0] frame_ctr_q;
  logic [HB_W-1:0]      heartbeat_q;
  logic [COORD_W-1:0]   bar_pos_q, bar_pos_d;
  logic [COORD_W-1:0]   bar_cnt_q, bar_cnt;
  logic [2:0]           bar_idx_q, bar_idx;
  logic                 line_start;
  logic [PhaseW-1:0]    hph, vph;
  logic                 hchk, vchk;
  logic                 in_bar;
  rgb_mask_t            mask;
  logic [3*COLOR_W-1:0] pix_rgb;
  logic [3*COLOR_W-1:0] out_rgb_q;
  logic                 out_de_q;

  assign frame_edge = next_frame & ~next_frame_q;
  assign line_start = de && (x == '0);

  pattern_phase_counter #(
    .Modulus (GRID_SPACING),
    .Width   (PhaseW)
  ) u_hphase (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .clear_i  (line_start),
    .en_i     (de),
    .phase_o  (hph),
    .toggle_o (hchk)
  );

  // Advances once per active line; y==0 pins it to the top of the grid.
  pattern_phase_counter #(
    .Modulus (GRID_SPACING),
    .Width   (PhaseW)
  ) u_vphase (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .clear_i  (line_start && (y == '0)),
    .en_i     (line_start && (y < COORD_W'(V_ACTIVE))),
    .phase_o  (vph),
    .toggle_o (vchk)
  );

  // Colour-bar position within the line; the last bar saturates.
  always_comb begin
    bar_cnt = bar_cnt_q;
    bar_idx = bar_idx_q;
    if (line_start) begin
      bar_cnt = '0;
      bar_idx = '0;
    end else if (de) begin
      if (bar_cnt_q == COORD_W'(BarW - 1)) begin
        bar_cnt = '0;
        bar_idx = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_cnt = bar_cnt_q + COORD_W'(1);
      end
    end
  end

  // Moving-bar step with wrap back into the active width.
  always_comb begin
    logic [CoordW1-1:0] sum;
    sum       = {1'b0, bar_pos_q} + CoordW1'(BAR_STEP);
    bar_pos_d = COORD_W'(sum);
    if (sum >= CoordW1'(H_ACTIVE)) begin
      bar_pos_d = COORD_W'(sum - CoordW1'(H_ACTIVE));
    end
  end

  assign in_bar = ({1'b0, x} >= {1'b0, bar_pos_q}) &&
                  ({1'b0, x} < ({1'b0, bar_pos_q} + CoordW1'(GRID_SPACING)));

  // Per-pixel colour from the frame-latched mode.
  always_comb begin
    mask    = BLACK;
    pix_rgb = '0;
    case (mode_q)
      MODE_GRID: begin
        if (vph == '0) begin
          mask = RED;
        end else if (hph == '0) begin
          mask = GREEN;
        end
      end
      MODE_BARS:   mask = BAR_COLORS[bar_idx];
      MODE_CHECK:  mask = (hchk ^ vchk) ? WHITE : BLACK;
      MODE_MOVBAR: mask = in_bar ? WHITE : BLACK;
      default:     mask = BLACK;
    endcase
    if (mode_q == MODE_SOLID) begin
      pix_rgb = solid_rgb;
    end else begin
      pix_rgb = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
    end
  end

  // Frame-rate state: edge detect, mode shadow, bar position and heartbeat.
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      next_frame_q <= 1'b0;
      mode_q       <= MODE_GRID;
      bar_pos_q    <= '0;
      frame_ctr_q  <= '0;
      heartbeat_q  <= '0;
    end else begin
      next_frame_q <= next_frame;
      if (frame_edge) begin
        mode_q    <= mode_e'(mode);
        bar_pos_q <= bar_pos_d;
        if (frame_ctr_q == FrameCtrW'(FRAMES_PER_BEAT - 1)) begin
          frame_ctr_q <= '0;
          heartbeat_q <= heartbeat_q + HB_W'(1);
        end else begin
          frame_ctr_q <= frame_ctr_q + FrameCtrW'(1);
        end
      end
    end
  end

  // Pixel-rate state: bar counters and the one-cycle output register.
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      out_rgb_q <= '0;
      out_de_q  <= 1'b0;
    end else begin
      bar_cnt_q <= bar_cnt;
      bar_idx_q <= bar_idx;
      out_de_q  <= de;
      out_rgb_q <= de ? pix_rgb : '0;
    end
  end

  assign out_r     = out_rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign out_g     = out_rgb_q[2*COLOR_W-1:COLOR_W];
  assign out_b     = out_rgb_q[COLOR_W-1:0];
  assign out_de    = out_de_q;
  assign heartbeat = heartbeat_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen; expected colours are written out by hand.
module tb_test_pattern_gen;

  logic        hdmi_clk = 1'b0;
  logic        reset;
  logic [11:0] x, y;
  logic        de;
  logic        next_frame;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_de;
  logic [7:0]  heartbeat;

  int n_checks = 0;
  int n_errors = 0;

  int          chk_x[$];
  logic [23:0] chk_c[$];

  test_pattern_gen dut (
    .hdmi_clk   (hdmi_clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .de         (de),
    .next_frame (next_frame),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_de     (out_de),
    .heartbeat  (heartbeat)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One pixel: apply inputs, clock once, land 1 time unit after the edge.
  task automatic pix(input int xx, input int yy, input logic d);
    x  = 12'(xx);
    y  = 12'(yy);
    de = d;
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic want(input int xx, input logic [23:0] c);
    chk_x.push_back(xx);
    chk_c.push_back(c);
  endtask

  // Drive x=0..xmax on line yy, checking the queued points, then one blank cycle.
  task automatic sweep(input string tag, input int yy, input int xmax);
    for (int i = 0; i <= xmax; i++) begin
      pix(i, yy, 1'b1);
      if (i == 0) check_eq({tag, "_de"}, {31'd0, out_de}, 32'd1);
      if (chk_x.size() != 0 && chk_x[0] == i) begin
        check_eq($sformatf("%s_y%0d_x%0d", tag, yy, i), {8'd0, out_r, out_g, out_b},
                 {8'd0, chk_c[0]});
        void'(chk_x.pop_front());
        void'(chk_c.pop_front());
      end
    end
    pix(0, yy, 1'b0);
    chk_x.delete();
    chk_c.delete();
  endtask

  task automatic frame_edge(input int hold);
    next_frame = 1'b1;
    for (int i = 0; i < hold; i++) pix(0, 0, 1'b0);
    next_frame = 1'b0;
    pix(0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; de = 1'b0; next_frame = 1'b0;
    mode = 3'd0; solid_rgb = '0;
    @(posedge hdmi_clk); #1;
    @(posedge hdmi_clk); #1;
    check_eq("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
    check_eq("rst_de", {31'd0, out_de}, 32'd0);
    check_eq("rst_hb", {24'd0, heartbeat}, 32'd0);
    reset = 1'b0;

    // Grid over every line; full sweeps only where points are checked.
    frame_edge(1);
    for (int yy = 0; yy < 1080; yy++) begin
      if (yy == 0) begin
        want(0, 24'hFF0000); want(7, 24'hFF0000); want(1919, 24'hFF0000);
        sweep("grid", yy, 1919);
      end else if (yy == 5) begin
        want(0, 24'h00FF00); want(24, 24'h000000); want(25, 24'h00FF00);
        want(1900, 24'h00FF00);
        sweep("grid", yy, 1919);
        check_eq("blank_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        check_eq("blank_de", {31'd0, out_de}, 32'd0);
      end else if (yy == 25) begin
        want(0, 24'hFF0000); want(24, 24'hFF0000); want(25, 24'hFF0000);
        sweep("grid", yy, 25);
      end else if (yy == 1075) begin
        want(3, 24'hFF0000); want(1000, 24'hFF0000);
        sweep("grid", yy, 1000);
      end else begin
        pix(0, yy, 1'b1);
        pix(0, yy, 1'b0);
      end
    end

    // Colour bars.
    mode = 3'd1;
    frame_edge(1);
    want(0, 24'hFFFFFF); want(239, 24'hFFFFFF); want(240, 24'hFFFF00);
    want(480, 24'h00FFFF); want(1680, 24'h000000);
    sweep("bars", 10, 1680);

    // Checkerboard.
    mode = 3'd2;
    frame_edge(1);
    want(0, 24'h000000); want(24, 24'h000000); want(25, 24'hFFFFFF);
    want(49, 24'hFFFFFF); want(50, 24'h000000);
    sweep("check", 0, 50);
    for (int yy = 1; yy < 25; yy++) begin
      pix(0, yy, 1'b1);
      pix(0, yy, 1'b0);
    end
    want(0, 24'hFFFFFF);
    sweep("check", 25, 0);

    // Mode change mid-line only takes effect at the next frame edge.
    mode = 3'd0;
    frame_edge(1);
    solid_rgb = 24'h123456;
    want(5, 24'hFF0000);
    sweep("chg", 0, 9);
    mode = 3'd3;
    want(12, 24'hFF0000); want(25, 24'hFF0000);
    sweep("chg", 0, 30);
    next_frame = 1'b1;
    pix(0, 0, 1'b1);
    check_eq("edge_old_mode", {8'd0, out_r, out_g, out_b}, 32'hFF0000);
    pix(1, 0, 1'b1);
    check_eq("edge_new_mode", {8'd0, out_r, out_g, out_b}, 32'h123456);
    next_frame = 1'b0;
    pix(2, 0, 1'b1);
    check_eq("solid", {8'd0, out_r, out_g, out_b}, 32'h123456);
    solid_rgb = 24'hABCDEF;
    pix(3, 0, 1'b1);
    check_eq("solid_live", {8'd0, out_r, out_g, out_b}, 32'hABCDEF);
    pix(0, 0, 1'b0);

    // Moving bar and heartbeat from a clean reset; next_frame held 3 cycles per frame.
    reset = 1'b1;
    pix(0, 0, 1'b0);
    reset = 1'b0;
    mode = 3'd4;
    frame_edge(3);
    want(3, 24'h000000); want(4, 24'hFFFFFF); want(28, 24'hFFFFFF); want(29, 24'h000000);
    sweep("movbar1", 0, 30);
    for (int f = 2; f <= 59; f++) frame_edge(3);
    check_eq("hb_f59", {24'd0, heartbeat}, 32'd0);
    frame_edge(3);
    check_eq("hb_f60", {24'd0, heartbeat}, 32'd1);
    frame_edge(3);
    check_eq("hb_f61", {24'd0, heartbeat}, 32'd1);
    for (int f = 62; f <= 479; f++) frame_edge(3);
    check_eq("hb_f479", {24'd0, heartbeat}, 32'd7);
    want(1915, 24'h000000); want(1916, 24'hFFFFFF); want(1919, 24'hFFFFFF);
    sweep("movbar479", 0, 1919);
    frame_edge(3);
    check_eq("hb_f480", {24'd0, heartbeat}, 32'd8);
    want(0, 24'hFFFFFF); want(24, 24'hFFFFFF); want(25, 24'h000000);
    sweep("movbar_wrap", 0, 30);

    // One-cycle reset mid-line.
    pix(0, 0, 1'b1);
    pix(1, 0, 1'b1);
    reset = 1'b1;
    pix(2, 0, 1'b1);
    check_eq("midrst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
    check_eq("midrst_de", {31'd0, out_de}, 32'd0);
    check_eq("midrst_hb", {24'd0, heartbeat}, 32'd0);
    reset = 1'b0;
    want(0, 24'hFF0000); want(1, 24'hFF0000);
    sweep("postrst_grid", 0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
